// File: rtl/icode_issue_pkg.sv
// Shared types and constants for the ICODE issue stage.
// Used by the issue FSM (icode_issue_unit) and by anything modelling host commands.
package icode_issue_pkg;

   localparam int ICODE_W = 8;
   localparam int REP_W_DEF = 4;
   localparam logic [ICODE_W-1:0] NOP_ADDR_DEF = 8'hFF;

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } issue_state_e;

   typedef struct packed {
      logic [ICODE_W-1:0]   addr;
      logic [REP_W_DEF-1:0] rep;
   } icode_entry_t;

endpackage

// File: rtl/icode_issue_if.sv
// Host command channel into the issue stage: valid/ready plus {addr, repeat}.
interface icode_issue_if #(
   parameter int REP_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       in_addr;
   logic [REP_W-1:0] in_rep;

   modport master (output in_valid, output in_addr, output in_rep, input in_ready);
   modport slave  (input in_valid, input in_addr, input in_rep, output in_ready);
endinterface

// File: rtl/icode_fifo.sv
// Synchronous show-ahead FIFO: head entry is visible on pop_data without a read cycle,
// so the issue FSM can chain entries with no bubble.
module icode_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 12
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [W-1:0]             push_data,
   input  logic                     pop,
   output logic [W-1:0]             pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_push_ok;
   logic          w_pop_ok;

   // A push into a full FIFO is refused even if a pop frees a slot at the same edge.
   assign full      = (r_count == (AW+1)'(DEPTH));
   assign empty     = (r_count == '0);
   assign w_push_ok = push && !full;
   assign w_pop_ok  = pop && !empty;
   assign pop_data  = r_mem[r_rd_ptr];
   assign level     = r_count;

   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: rtl/icode_issue_unit.sv
// Issue stage feeding the processor's ICODE input every cycle; emits NOP_ADDR when idle/paused.
// Optional ICODE_ISSUE_STATS_EN adds stat_clr / stat_issued / stat_nop counters.
module icode_issue_unit
   import icode_issue_pkg::*;
#(
   parameter int                 DEPTH    = 8,
   parameter int                 REP_W    = REP_W_DEF,
   parameter logic [ICODE_W-1:0] NOP_ADDR = NOP_ADDR_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   icode_issue_if.slave             host,
   input  logic                     enable,
   output logic [ICODE_W-1:0]       icode,
   output logic                     icode_is_nop,
   output logic                     busy,
`ifdef ICODE_ISSUE_STATS_EN
   input  logic                     stat_clr,
   output logic [15:0]              stat_issued,
   output logic [15:0]              stat_nop,
`endif
   output logic [$clog2(DEPTH):0]   fifo_level
);
   localparam int EW = ICODE_W + REP_W;

   issue_state_e       r_state;
   logic [ICODE_W-1:0] r_addr;
   logic [REP_W-1:0]   r_rem;
   logic [ICODE_W-1:0] r_icode;
   logic               r_is_nop;

   logic               w_full;
   logic               w_empty;
   logic               w_pop;
   logic [EW-1:0]      w_head;
   logic [ICODE_W-1:0] w_head_addr;
   logic [REP_W-1:0]   w_head_rep;

   assign host.in_ready = !w_full && !rst;
   assign w_head_addr   = w_head[REP_W +: ICODE_W];
   assign w_head_rep    = w_head[REP_W-1:0];

   icode_fifo #(
      .DEPTH (DEPTH),
      .W     (EW)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (host.in_valid && host.in_ready),
      .push_data ({host.in_addr, host.in_rep}),
      .pop       (w_pop),
      .pop_data  (w_head),
      .full      (w_full),
      .empty     (w_empty),
      .level     (fifo_level)
   );

   // Pop when idle, or when the current burst has used its last repeat.
   always_comb begin
      w_pop = 1'b0;
      if (enable && !w_empty) begin
         if (r_state == IDLE || r_rem == '0) w_pop = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_addr   <= NOP_ADDR;
         r_rem    <= '0;
         r_icode  <= NOP_ADDR;
         r_is_nop <= 1'b1;
      end else begin
         if (w_pop) begin
            r_state  <= ISSUE;
            r_addr   <= w_head_addr;
            r_rem    <= w_head_rep;
            r_icode  <= w_head_addr;
            r_is_nop <= 1'b0;
         end else if (r_state == ISSUE && enable && r_rem != '0) begin
            // Also resumes a paused burst; addr and rem were frozen during the pause.
            r_icode  <= r_addr;
            r_is_nop <= 1'b0;
            r_rem    <= r_rem - 1'b1;
         end else begin
            r_icode  <= NOP_ADDR;
            r_is_nop <= 1'b1;
            if (r_state == ISSUE && enable) r_state <= IDLE;
         end
      end
   end

   assign icode        = r_icode;
   assign icode_is_nop = r_is_nop;
   assign busy         = (r_state == ISSUE) || (fifo_level != '0);

`ifdef ICODE_ISSUE_STATS_EN
   logic [15:0] r_stat_issued;
   logic [15:0] r_stat_nop;

   always_ff @(posedge clk) begin
      if (rst || stat_clr) begin
         r_stat_issued <= '0;
         r_stat_nop    <= '0;
      end else if (r_is_nop) begin
         if (r_stat_nop != 16'hFFFF) r_stat_nop <= r_stat_nop + 1'b1;
      end else begin
         if (r_stat_issued != 16'hFFFF) r_stat_issued <= r_stat_issued + 1'b1;
      end
   end

   assign stat_issued = r_stat_issued;
   assign stat_nop    = r_stat_nop;
`endif
endmodule

// File: tb/tb_icode_issue_unit.sv
// Bench for icode_issue_unit: directed scenarios then random traffic, checked against
// a stream model where each accepted command expands into rep+1 issue slots.
module tb_icode_issue_unit;
   import icode_issue_pkg::*;

   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic [7:0] icode;
   logic       icode_is_nop;
   logic       busy;
   logic [3:0] fifo_level;
`ifdef ICODE_ISSUE_STATS_EN
   logic        stat_clr;
   logic [15:0] stat_issued;
   logic [15:0] stat_nop;
`endif

   icode_issue_if #(.REP_W(4)) host_if ();

   always #5 clk = ~clk;

   icode_issue_unit #(.DEPTH(DEPTH), .REP_W(4), .NOP_ADDR(8'hFF)) dut (
      .clk          (clk),
      .rst          (rst),
      .host         (host_if),
      .enable       (enable),
      .icode        (icode),
      .icode_is_nop (icode_is_nop),
      .busy         (busy),
`ifdef ICODE_ISSUE_STATS_EN
      .stat_clr     (stat_clr),
      .stat_issued  (stat_issued),
      .stat_nop     (stat_nop),
`endif
      .fifo_level   (fifo_level)
   );

   typedef struct {
      logic [7:0] addr;
      bit         first;
   } slot_t;

   slot_t      slots[$];
   int         m_level  = 0;
   bit         m_active = 0;
   logic [7:0] m_icode  = 8'hFF;
   bit         m_nop    = 1;
   int         m_issued = 0;
   int         m_nopcnt = 0;
   int         n_vec    = 0;
   int         n_err    = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step(input bit r, input bit v, input logic [7:0] a, input logic [3:0] rp,
                       input bit en, input bit clr);
      bit           exp_ready;
      slot_t        s;
      icode_entry_t e;
      rst              = r;
      host_if.in_valid = v;
      host_if.in_addr  = a;
      host_if.in_rep   = rp;
      enable           = en;
`ifdef ICODE_ISSUE_STATS_EN
      stat_clr = clr;
`endif
      #1;
      exp_ready = !r && (m_level < DEPTH);
      check_val("in_ready", {31'd0, host_if.in_ready}, {31'd0, exp_ready});
      @(posedge clk);
      // Counters see the value that was on icode_is_nop during the cycle just ended.
      if (r || clr) begin
         m_issued = 0;
         m_nopcnt = 0;
      end else if (m_nop) begin
         if (m_nopcnt < 65535) m_nopcnt++;
      end else begin
         if (m_issued < 65535) m_issued++;
      end
      if (r) begin
         slots.delete();
         m_level  = 0;
         m_active = 0;
         m_icode  = 8'hFF;
         m_nop    = 1;
      end else begin
         if (en && slots.size() > 0) begin
            s = slots.pop_front();
            if (s.first) m_level--;
            m_icode  = s.addr;
            m_nop    = 0;
            m_active = 1;
         end else begin
            m_icode = 8'hFF;
            m_nop   = 1;
            if (en) m_active = 0;
         end
         if (v && exp_ready) begin
            e.addr = a;
            e.rep  = rp;
            for (int i = 0; i <= int'(e.rep); i++) begin
               s.addr  = e.addr;
               s.first = (i == 0);
               slots.push_back(s);
            end
            m_level++;
         end
      end
      #1;
      check_val("icode", {24'd0, icode}, {24'd0, m_icode});
      check_val("icode_is_nop", {31'd0, icode_is_nop}, {31'd0, m_nop});
      check_val("busy", {31'd0, busy}, {31'd0, (m_active || m_level != 0)});
      check_val("fifo_level", {28'd0, fifo_level}, 32'(m_level));
`ifdef ICODE_ISSUE_STATS_EN
      check_val("stat_issued", {16'd0, stat_issued}, 32'(m_issued));
      check_val("stat_nop", {16'd0, stat_nop}, 32'(m_nopcnt));
`endif
   endtask

   task automatic idle(input int n, input bit en);
      for (int i = 0; i < n; i++) step(0, 0, 8'h00, 4'd0, en, 0);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) step(1, 0, 8'h00, 4'd0, 1, 0);
      idle(5, 1);
      // Single burst of three issues.
      step(0, 1, 8'h10, 4'd2, 1, 0);
      idle(4, 1);
      step(0, 1, 8'h11, 4'd1, 1, 1);
      idle(4, 1);
      // Back-to-back entries chain with no bubble.
      step(0, 1, 8'h20, 4'd0, 1, 0);
      step(0, 1, 8'h21, 4'd1, 1, 0);
      step(0, 1, 8'h22, 4'd0, 1, 0);
      idle(6, 1);
      // Fill while paused; the ninth push must be refused.
      for (int i = 0; i < 9; i++) step(0, 1, 8'(8'h40 + i), 4'(i % 3), 0, 0);
      idle(25, 1);
      // Pause mid-burst, resume, then reset mid-burst.
      step(0, 1, 8'h30, 4'd5, 1, 0);
      idle(2, 1);
      idle(3, 0);
      idle(4, 1);
      step(0, 1, 8'h31, 4'd7, 1, 0);
      step(0, 1, 8'hFF, 4'd2, 1, 0);
      idle(2, 1);
      step(1, 0, 8'h00, 4'd0, 1, 0);
      idle(4, 1);
      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         logic [7:0] a;
         a = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
         step(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1), a,
              4'($urandom), ($urandom_range(0, 9) < 8), ($urandom_range(0, 99) == 0));
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
